regfile_wport_arbiter: RTL and testbench

Shares the single register-file write port between NREQ writeback requesters (ALU, load unit, multiplier, CSR/move unit) using a round-robin policy. It accepts one write per cycle through a valid/ready handshake. It registers the winning address and data, and drives the register file's one-hot 32-bit write-enable vector directly, which replaces the standalone address decode on the write port. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_wport_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wport_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Registers the winning write and drives a one-hot write-enable vector.
module regfile_wport_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int R0_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wp_stall,
  output logic                     wr_valid,
  output logic [2**AW-1:0]         wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic [$clog2(NREQ)-1:0]  wr_src
);

  localparam int PW = $clog2(NREQ);
  localparam int NE = 2**AW;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wrValid_q, wrValid_d;
  logic [NE-1:0]   wrEn_q, wrEn_d;
  logic [AW-1:0]   wrAddr_q, wrAddr_d;
  logic [DW-1:0]   wrData_q, wrData_d;
  logic [PW-1:0]   wrSrc_q, wrSrc_d;

  logic [NREQ-1:0] grant;
  logic            grantValid;
  logic [PW-1:0]   grantIdx;
  logic [AW-1:0]   selAddr;
  logic [DW-1:0]   selData;
  int              idx;

  // Scan upward from ptr with wrap; first valid requester wins.
  always_comb begin
    grant      = '0;
    grantValid = 1'b0;
    grantIdx   = '0;
    idx        = 0;
    if (!reset && !wp_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!grantValid && req_valid[idx]) begin
          grantValid = 1'b1;
          grantIdx   = PW'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign selAddr   = req_addr[int'(grantIdx)*AW +: AW];
  assign selData   = req_data[int'(grantIdx)*DW +: DW];

  always_comb begin
    ptr_d     = ptr_q;
    wrValid_d = 1'b0;
    wrEn_d    = '0;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;
    wrSrc_d   = wrSrc_q;
    if (grantValid) begin
      ptr_d     = (grantIdx == PW'(NREQ-1)) ? '0 : grantIdx + 1'b1;
      wrValid_d = 1'b1;
      wrAddr_d  = selAddr;
      wrData_d  = selData;
      wrSrc_d   = grantIdx;
      // Register 0 is hardwired: complete the handshake but write nothing.
      if (!(R0_ZERO != 0 && selAddr == '0)) begin
        wrEn_d[selAddr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      wrValid_q <= 1'b0;
      wrEn_q    <= '0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      wrSrc_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wrValid_q <= wrValid_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      wrSrc_q   <= wrSrc_d;
    end
  end

  assign wr_valid = wrValid_q;
  assign wr_en    = wrEn_q;
  assign wr_addr  = wrAddr_q;
  assign wr_data  = wrData_q;
  assign wr_src   = wrSrc_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_regfile_wport_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wp_stall;
  logic            wr_valid;
  logic [31:0]     wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [1:0]      wr_src;

  regfile_wport_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wp_stall(wp_stall),
    .wr_valid(wr_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_src(wr_src)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus state per requester
  logic          vA [N];
  logic [AW-1:0] aA [N];
  logic [DW-1:0] dA [N];
  logic          rstIn, stallIn;

  // Reference model state
  int            mPtr;
  logic          mWrValid;
  logic [31:0]   mWrEn;
  logic [AW-1:0] mWrAddr;
  logic [DW-1:0] mWrData;
  int            mWrSrc;
  int            lastGrant;
  logic [N-1:0]  obsReady;
  int            grantCount [N];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = vA[i];
      req_addr[i*AW +: AW]  = aA[i];
      req_data[i*DW +: DW]  = dA[i];
    end
    reset    = rstIn;
    wp_stall = stallIn;
  endtask

  function automatic int modelGrant();
    if (rstIn || stallIn) return -1;
    for (int k = 0; k < N; k++) begin
      if (vA[(mPtr + k) % N]) return (mPtr + k) % N;
    end
    return -1;
  endfunction

  // One clock: check everything at the negedge, then advance the model past the posedge.
  task automatic runCycle();
    int g;
    logic [N-1:0] expReady;
    applyStimulus();
    @(negedge clk);
    g = modelGrant();
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    obsReady = req_ready;
    checkOutput("req_ready", 64'(req_ready), 64'(expReady));
    checkOutput("wr_valid",  64'(wr_valid),  64'(mWrValid));
    checkOutput("wr_en",     64'(wr_en),     64'(mWrEn));
    checkOutput("wr_addr",   64'(wr_addr),   64'(mWrAddr));
    checkOutput("wr_data",   64'(wr_data),   64'(mWrData));
    checkOutput("wr_src",    64'(wr_src),    64'(mWrSrc));
    @(posedge clk);
    #1;
    lastGrant = g;
    if (rstIn) begin
      mPtr = 0; mWrValid = 1'b0; mWrEn = '0; mWrAddr = '0; mWrData = '0; mWrSrc = 0;
    end else if (g >= 0) begin
      grantCount[g]++;
      mPtr     = (g + 1) % N;
      mWrValid = 1'b1;
      mWrAddr  = aA[g];
      mWrData  = dA[g];
      mWrSrc   = g;
      mWrEn    = (aA[g] == 0) ? 32'h0 : (32'h1 << aA[g]);
    end else begin
      mWrValid = 1'b0;
      mWrEn    = '0;
    end
  endtask

  task automatic idleAll();
    for (int i = 0; i < N; i++) begin
      vA[i] = 1'b0; aA[i] = '0; dA[i] = '0;
    end
    rstIn = 1'b0; stallIn = 1'b0;
  endtask

  task automatic doReset();
    rstIn = 1'b1;
    runCycle();
    rstIn = 1'b0;
  endtask

  initial begin
    mPtr = 0; mWrValid = 0; mWrEn = '0; mWrAddr = '0; mWrData = '0; mWrSrc = 0;
    lastGrant = -1; obsReady = '0;
    for (int i = 0; i < N; i++) grantCount[i] = 0;
    idleAll();

    // Reset with every requester asking: nothing granted, no enable
    for (int i = 0; i < N; i++) begin
      vA[i] = 1'b1; aA[i] = AW'(i + 1); dA[i] = 32'h1000 + i;
    end
    rstIn = 1'b1;
    runCycle();
    checkOutput("rstReady", 64'(obsReady), 64'h0);
    runCycle();
    checkOutput("rstWrEn", 64'(wr_en), 64'h0);
    rstIn = 1'b0;
    runCycle();
    checkOutput("firstGrant", 64'(obsReady), 64'h1);

    // Single request from requester 2
    idleAll();
    doReset();
    vA[2] = 1'b1; aA[2] = 5'd7; dA[2] = 32'hDEADBEEF;
    runCycle();
    checkOutput("singleReady", 64'(obsReady), 64'h4);
    checkOutput("singleEn",    64'(wr_en),    64'h00000080);
    checkOutput("singleData",  64'(wr_data),  64'hDEADBEEF);
    checkOutput("singleSrc",   64'(wr_src),   64'd2);
    // ptr is now 3: requesters 0 and 3 valid -> 3 first, then 0
    vA[2] = 1'b0;
    vA[0] = 1'b1; aA[0] = 5'd4; dA[0] = 32'hA0;
    vA[3] = 1'b1; aA[3] = 5'd5; dA[3] = 32'hA3;
    runCycle();
    checkOutput("wrapFirst", 64'(obsReady), 64'h8);
    vA[3] = 1'b0;
    runCycle();
    checkOutput("wrapSecond", 64'(obsReady), 64'h1);

    // Round-robin fairness, all continuously valid
    idleAll();
    doReset();
    for (int i = 0; i < N; i++) begin
      vA[i] = 1'b1; aA[i] = AW'(8 + i); dA[i] = 32'hC0DE0000 + i; grantCount[i] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      runCycle();
      checkOutput("rrOrder", 64'(obsReady), 64'(1) << (c % N));
    end
    for (int i = 0; i < N; i++) checkOutput("rrCount", 64'(grantCount[i]), 64'd2);

    // Address sweep through requester 1
    idleAll();
    vA[1] = 1'b1;
    for (int a = 0; a < 32; a++) begin
      aA[1] = AW'(a); dA[1] = 32'h5000 + a;
      runCycle();
      checkOutput("sweepEn", 64'(wr_en), (a == 0) ? 64'h0 : (64'h1 << a));
      checkOutput("sweepValid", 64'(wr_valid), 64'h1);
    end

    // Stall for 3 cycles with requests pending
    idleAll();
    doReset();
    for (int i = 0; i < N; i++) begin
      vA[i] = 1'b1; aA[i] = AW'(16 + i); dA[i] = 32'hBEEF0000 + i;
    end
    runCycle();
    vA[0] = 1'b0;
    stallIn = 1'b1;
    runCycle();
    checkOutput("stallReady", 64'(obsReady), 64'h0);
    runCycle();
    runCycle();
    stallIn = 1'b0;
    runCycle();
    checkOutput("stallResume", 64'(obsReady), 64'h2);

    // Reset arriving together with a request: no enable pulse, ptr back to 0
    idleAll();
    vA[1] = 1'b1; aA[1] = 5'd9; dA[1] = 32'h99;
    rstIn = 1'b1;
    runCycle();
    rstIn = 1'b0;
    vA[1] = 1'b0;
    runCycle();
    checkOutput("rstMidEn", 64'(wr_en), 64'h0);
    // Reset while a write is being presented discards it
    vA[1] = 1'b1;
    runCycle();
    vA[1] = 1'b0;
    rstIn = 1'b1;
    runCycle();
    rstIn = 1'b0;
    checkOutput("rstDiscard", 64'(wr_en), 64'h0);
    vA[0] = 1'b1; vA[3] = 1'b1;
    runCycle();
    checkOutput("rstPtr", 64'(obsReady), 64'h1);

    // Random traffic obeying the hold-until-ready rule
    idleAll();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (lastGrant == i) vA[i] = 1'b0;
        if (!vA[i] && ($urandom_range(1, 0) == 1)) begin
          vA[i] = 1'b1;
          aA[i] = AW'($urandom);
          dA[i] = $urandom;
        end
      end
      stallIn = ($urandom_range(9, 0) < 2);
      rstIn   = ($urandom_range(49, 0) == 0);
      runCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
